// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and defaults for the mux scan sampler.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } scan_state_t;

  localparam int DEF_NUM_CH = 16;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_SETTLE = 2;

  // A settle time of 1 still needs a one-bit counter, so never return zero.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_SETTLE);

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Select/sample and word handshake bundle between the scan sampler and its neighbours.
// Optional MUX_SCAN_PARITY_EN adds a word_parity signal.
interface mux_scan_sampler_if #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
);
  logic              start;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic              busy;
  logic [NUM_CH-1:0] word;
  logic              word_valid;
  logic              word_ready;
`ifdef MUX_SCAN_PARITY_EN
  logic              word_parity;
`endif

  modport master (
    input  start, mux_out, word_ready,
    output sel, busy, word, word_valid
`ifdef MUX_SCAN_PARITY_EN
    , output word_parity
`endif
  );

  modport slave (
    output start, mux_out, word_ready,
    input  sel, busy, word, word_valid
`ifdef MUX_SCAN_PARITY_EN
    , input word_parity
`endif
  );
endinterface

// File: rtl/mux_scan_sampler_settle_timer.sv
// Per-channel settle counter: counts while enabled, cleared between channels,
// flags the last settle cycle.
module mux_scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);
  localparam int W = cnt_width(SETTLE);
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_done = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps a 16:1 bit mux through every channel and assembles the samples into a word.
// Optional MUX_SCAN_PARITY_EN adds word_parity (XOR of the captured word).
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_scan_sampler_if.master bus
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  scan_state_t       r_state;
  scan_state_t       w_next_state;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_word;
  logic              w_busy;
  logic              w_valid;
  logic              w_tmr_en;
  logic              w_tmr_clr;
  logic              w_tmr_done;
  logic              w_last_ch;
  logic              w_scan_start;

  assign w_last_ch = (r_sel == LAST_SEL);

  // A new scan starts from IDLE, or straight out of DONE when the word is taken.
  assign w_scan_start = bus.start &&
                        ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.word_ready));

  mux_scan_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .o_done (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next_state = S_SETTLE;
      S_SETTLE: if (w_tmr_done) w_next_state = S_SAMPLE;
      S_SAMPLE: w_next_state = w_last_ch ? S_DONE : S_SETTLE;
      S_DONE: begin
        if (bus.word_ready) begin
          w_next_state = bus.start ? S_SETTLE : S_IDLE;
        end
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    w_valid   = (r_state == S_DONE);
    w_tmr_en  = (r_state == S_SETTLE);
    w_tmr_clr = (r_state != S_SETTLE);
  end

  // Unsampled channels keep last scan's bits; only reset clears the word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_word <= '0;
    end else if (w_scan_start) begin
      r_sel <= '0;
    end else if (r_state == S_SAMPLE) begin
      r_word[r_sel] <= bus.mux_out;
      if (!w_last_ch) begin
        r_sel <= r_sel + SEL_W'(1);
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_scan_start) begin
      r_parity <= 1'b0;
    end else if (r_state == S_SAMPLE) begin
      r_parity <= r_parity ^ bus.mux_out;
    end
  end

  assign bus.word_parity = r_parity;
`endif

  assign bus.sel        = r_sel;
  assign bus.word       = r_word;
  assign bus.busy       = w_busy;
  assign bus.word_valid = w_valid;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler with a behavioural 16:1 mux on the select.
// Define MUX_SCAN_PARITY_EN to also exercise word_parity.
module tb_mux_scan_sampler;
  logic        clk;
  logic        rst_n;
  logic [15:0] in_vec;
  int          total;
  int          bad;

  mux_scan_sampler_if #(.NUM_CH(16), .SEL_W(4)) bus ();

  mux_scan_sampler #(
    .NUM_CH (16),
    .SEL_W  (4),
    .SETTLE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // The mux under scan: a plain bit select of the input vector.
  assign bus.mux_out = in_vec[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int cycles, output bit ok);
    cycles = 0;
    while (bus.word_valid !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    ok = (bus.word_valid === 1'b1);
  endtask

  task automatic wait_sel(input logic [3:0] target, output bit ok);
    int n;
    n = 0;
    while (bus.sel !== target && n < 100) begin
      tick();
      n++;
    end
    ok = (bus.sel === target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.sel !== 4'd0) begin bad++; $display("[TB] FAIL reset_sel: got %0d want 0", bus.sel); end
    total++;
    if (bus.word !== 16'h0000) begin bad++; $display("[TB] FAIL reset_word: got %h want 0000", bus.word); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    total++;
    if (bus.word_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.word_valid); end
`ifdef MUX_SCAN_PARITY_EN
    total++;
    if (bus.word_parity !== 1'b0) begin bad++; $display("[TB] FAIL reset_parity: got %b want 0", bus.word_parity); end
`endif
  endtask

  task automatic test_scan_aaaa();
    logic [3:0] exp_sel;
    in_vec = 16'hAAAA;
    do_start();
    for (int j = 0; j < 48; j++) begin
      exp_sel = 4'(j / 3);
      total++;
      if (bus.sel !== exp_sel) begin
        bad++; $display("[TB] FAIL scan_sel cycle %0d: got %0d want %0d", j, bus.sel, exp_sel);
      end
      total++;
      if (bus.busy !== 1'b1 || bus.word_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL scan_flags cycle %0d: got busy=%b valid=%b want busy=1 valid=0",
                        j, bus.busy, bus.word_valid);
      end
      tick();
    end
    total++;
    if (bus.word_valid !== 1'b1) begin bad++; $display("[TB] FAIL scan_valid_48: got %b want 1", bus.word_valid); end
    total++;
    if (bus.word !== 16'hAAAA) begin bad++; $display("[TB] FAIL scan_word: got %h want aaaa", bus.word); end
    total++;
    if (bus.sel !== 4'd15 || bus.busy !== 1'b0) begin
      bad++; $display("[TB] FAIL scan_done_state: got sel=%0d busy=%b want sel=15 busy=0", bus.sel, bus.busy);
    end
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    total++;
    if (bus.word_valid !== 1'b0) begin bad++; $display("[TB] FAIL scan_ack: got valid=%b want 0", bus.word_valid); end
  endtask

  task automatic test_backpressure();
    int cycles;
    bit ok;
    in_vec = 16'h1234;
    do_start();
    wait_valid(cycles, ok);
    total++;
    if (!ok || cycles != 48) begin
      bad++; $display("[TB] FAIL bp_latency: got %0d cycles (valid=%b) want 48", cycles, bus.word_valid);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.word_valid !== 1'b1 || bus.word !== 16'h1234) begin
        bad++; $display("[TB] FAIL bp_hold %0d: got valid=%b word=%h want valid=1 word=1234",
                        i, bus.word_valid, bus.word);
      end
      tick();
    end
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    total++;
    if (bus.word_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 4'd15) begin
      bad++; $display("[TB] FAIL bp_release: got valid=%b busy=%b sel=%0d want 0 0 15",
                      bus.word_valid, bus.busy, bus.sel);
    end
    tick();
    total++;
    if (bus.word_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_idle: got valid=%b busy=%b want 0 0", bus.word_valid, bus.busy);
    end
  endtask

  task automatic test_start_ignored();
    int          rises;
    int          rise_at;
    int          pulses;
    logic        prev_valid;
    logic        start_prev;
    logic [15:0] cap;
    in_vec = 16'h5A3C;
    bus.word_ready = 1'b1;
    do_start();
    rises = 0;
    rise_at = -1;
    pulses = 0;
    prev_valid = 1'b0;
    start_prev = 1'b0;
    cap = '0;
    for (int j = 0; j < 120; j++) begin
      if (start_prev) begin
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL ign_busy cycle %0d: got %b want 1", j, bus.busy); end
      end
      if (bus.word_valid === 1'b1 && !prev_valid) begin
        rises++;
        if (rise_at < 0) begin
          rise_at = j;
          cap = bus.word;
        end
      end
      prev_valid = bus.word_valid;
      if (bus.sel === 4'd7 && bus.busy === 1'b1 && pulses < 3) begin
        bus.start = 1'b1;
        pulses++;
      end else begin
        bus.start = 1'b0;
      end
      start_prev = bus.start;
      tick();
    end
    bus.start = 1'b0;
    bus.word_ready = 1'b0;
    total++;
    if (rises != 1) begin bad++; $display("[TB] FAIL ign_words: got %0d words want 1", rises); end
    total++;
    if (rise_at != 48) begin bad++; $display("[TB] FAIL ign_latency: got %0d want 48", rise_at); end
    total++;
    if (cap !== 16'h5A3C) begin bad++; $display("[TB] FAIL ign_word: got %h want 5a3c", cap); end
    total++;
    if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL ign_idle: got busy=%b valid=%b want 0 0", bus.busy, bus.word_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit ok;
    in_vec = 16'h3C5A;
    do_start();
    wait_valid(cycles, ok);
    total++;
    if (!ok || bus.word !== 16'h3C5A) begin
      bad++; $display("[TB] FAIL b2b_first: got valid=%b word=%h want 1 3c5a", bus.word_valid, bus.word);
    end
    in_vec = 16'h00FF;
    bus.word_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.sel !== 4'd0 || bus.word_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_restart: got busy=%b sel=%0d valid=%b want 1 0 0",
                      bus.busy, bus.sel, bus.word_valid);
    end
    wait_valid(cycles, ok);
    total++;
    if (!ok || cycles != 48) begin bad++; $display("[TB] FAIL b2b_latency: got %0d want 48", cycles); end
    total++;
    if (bus.word !== 16'h00FF) begin bad++; $display("[TB] FAIL b2b_word: got %h want 00ff", bus.word); end
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int cycles;
    bit ok;
    in_vec = 16'hFFFF;
    do_start();
    wait_sel(4'd5, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL rst_reach_sel5: got sel=%0d want 5", bus.sel); end
    rst_n = 1'b0;
    tick();
    total++;
    if (bus.sel !== 4'd0 || bus.word !== 16'h0000 || bus.busy !== 1'b0 || bus.word_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_mid: got sel=%0d word=%h busy=%b valid=%b want 0 0000 0 0",
                      bus.sel, bus.word, bus.busy, bus.word_valid);
    end
    rst_n = 1'b1;
    tick();
    in_vec = 16'h0F0F;
    do_start();
    wait_valid(cycles, ok);
    total++;
    if (!ok || cycles != 48) begin bad++; $display("[TB] FAIL rst_fresh_latency: got %0d want 48", cycles); end
    total++;
    if (bus.word !== 16'h0F0F) begin bad++; $display("[TB] FAIL rst_fresh_word: got %h want 0f0f", bus.word); end
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask

`ifdef MUX_SCAN_PARITY_EN
  task automatic test_parity();
    int cycles;
    bit ok;
    in_vec = 16'h0001;
    do_start();
    wait_valid(cycles, ok);
    total++;
    if (!ok || bus.word !== 16'h0001 || bus.word_parity !== 1'b1) begin
      bad++; $display("[TB] FAIL parity_odd: got word=%h parity=%b want 0001 1", bus.word, bus.word_parity);
    end
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    in_vec = 16'h0003;
    do_start();
    wait_valid(cycles, ok);
    total++;
    if (!ok || bus.word !== 16'h0003 || bus.word_parity !== 1'b0) begin
      bad++; $display("[TB] FAIL parity_even: got word=%h parity=%b want 0003 0", bus.word, bus.word_parity);
    end
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_vec = 16'h0000;
    bus.start = 1'b0;
    bus.word_ready = 1'b0;
    tick();
    test_reset();
    test_scan_aaaa();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef MUX_SCAN_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
